// File: rtl/instr_fetch_mem.sv
// Instruction memory with a single-outstanding fetch handshake and a runtime program-load port.
// Faulting PCs (misaligned / out of range) answer one cycle early with a NOP and a cause code.
//   state | meaning
//   IDLE  | ready for a fetch, response fields cleared
//   READ  | synchronous word read in flight
//   RESP  | response presented until instr_ack_i
module instr_fetch_mem #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 64,
  parameter int              ADDR_W   = $clog2(DEPTH),
  parameter logic [XLEN-1:0] PC_BASE  = '0,
  parameter logic [XLEN-1:0] NOP_INSN = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic              fetch_ready_o,
  output logic [XLEN-1:0]   instr_o,
  output logic              instr_valid_o,
  input  logic              instr_ack_i,
  output logic              fault_o,
  output logic [1:0]        fault_cause_o,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [XLEN-1:0]   prog_data_i
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE = 2'b10;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     instr_q, instr_d;
  logic                fault_q, fault_d;
  logic [1:0]          cause_q, cause_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;

  logic [XLEN-1:0]     mem_q [DEPTH];

  logic [XLEN:0]       pc_ext, base_ext, limit_ext;
  logic [XLEN-1:0]     pc_off;
  logic [ADDR_W-1:0]   pc_idx;
  logic                misaligned, out_of_range;

  // Range limits are compared one bit wider so a PC near the top of the space cannot wrap in.
  assign pc_ext       = {1'b0, pc_i};
  assign base_ext     = {1'b0, PC_BASE};
  assign limit_ext    = base_ext + (XLEN+1)'(4 * DEPTH);
  assign misaligned   = (pc_i[1:0] != 2'b00);
  assign out_of_range = (pc_ext < base_ext) || (pc_ext >= limit_ext);
  assign pc_off       = pc_i - PC_BASE;
  assign pc_idx       = ADDR_W'(pc_off >> 2);

  always_ff @(posedge clk) begin
    if (prog_we_i) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    fault_d = fault_q;
    cause_d = cause_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (fetch_req_i) begin
          if (misaligned || out_of_range) begin
            state_d = RESP;
            instr_d = NOP_INSN;
            fault_d = 1'b1;
            cause_d = misaligned ? CAUSE_ALIGN : CAUSE_RANGE;
          end else begin
            state_d = READ;
            idx_d   = pc_idx;
          end
        end
      end
      READ: begin
        // mem_q still holds the pre-edge word here, so a same-cycle load is not seen.
        state_d = RESP;
        instr_d = mem_q[idx_q];
        fault_d = 1'b0;
        cause_d = CAUSE_NONE;
      end
      RESP: begin
        if (instr_ack_i) begin
          state_d = IDLE;
          fault_d = 1'b0;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fetch_ready_o = (state_q == IDLE);
  assign instr_valid_o = (state_q == RESP);
  assign instr_o       = instr_q;
  assign fault_o       = fault_q;
  assign fault_cause_o = cause_q;

endmodule
